// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with x0 hardwired to zero, write-port
// arbitration with collision reporting, optional write-to-read bypass and a
// per-register pending scoreboard for hazard detection.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   RADDR/RDATA  NUM_RD packed read ports (RDATA combinational)
//   RBUSY        pending flag of each read address (combinational)
//   WE/WADDR/WDATA  NUM_WR packed write ports; lowest port wins per address
//   RSV_EN/RSV_ADDR reserve a destination register (set its pending bit)
//   WCOLL        registered; bit j pulses one cycle after port j lost
module regfile_mp_sb #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_RD     = 4,
    parameter int unsigned NUM_WR     = 2,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   RADDR,
    output logic [NUM_RD*DATA_WIDTH-1:0]   RDATA,
    output logic [NUM_RD-1:0]              RBUSY,
    input  logic [NUM_WR-1:0]              WE,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]   WADDR,
    input  logic [NUM_WR*DATA_WIDTH-1:0]   WDATA,
    input  logic                           RSV_EN,
    input  logic [ADDR_WIDTH-1:0]          RSV_ADDR,
    output logic [NUM_WR-1:0]              WCOLL
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      pend;
    logic [DEPTH-1:0]      pend_nxt;

    logic [ADDR_WIDTH-1:0] waddr [NUM_WR];
    logic [DATA_WIDTH-1:0] wdata [NUM_WR];
    logic [NUM_WR-1:0]     wact;
    logic [NUM_WR-1:0]     win;
    logic [NUM_WR-1:0]     lose;

    // Unpack write ports and arbitrate: a port loses if any lower active port
    // targets the same nonzero address. Writes to x0 are neither active nor lost.
    always_comb begin
        wact = '0;
        win  = '0;
        lose = '0;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            waddr[j] = WADDR[j*ADDR_WIDTH +: ADDR_WIDTH];
            wdata[j] = WDATA[j*DATA_WIDTH +: DATA_WIDTH];
            wact[j]  = WE[j] && (waddr[j] != '0);
        end
        win = wact;
        for (int unsigned j = 1; j < NUM_WR; j++) begin
            for (int unsigned k = 0; k < j; k++) begin
                if (wact[k] && wact[j] && (waddr[k] == waddr[j])) begin
                    win[j]  = 1'b0;
                    lose[j] = 1'b1;
                end
            end
        end
    end

    // Scoreboard update: writes clear, a reservation applied last so the new
    // producer wins when the same register is reserved and written together.
    always_comb begin
        pend_nxt = pend;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (wact[j]) begin
                pend_nxt[waddr[j]] = 1'b0;
            end
        end
        if (RSV_EN && (RSV_ADDR != '0)) begin
            pend_nxt[RSV_ADDR] = 1'b1;
        end
    end

    // Storage, scoreboard and collision flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pend  <= '0;
            WCOLL <= '0;
        end else begin
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (win[j]) begin
                    mem[waddr[j]] <= wdata[j];
                end
            end
            pend  <= pend_nxt;
            WCOLL <= lose;
        end
    end

    // Read ports: storage value, optionally overridden by this cycle's winning
    // write. Winners are unique per address, so at most one bypass hit exists.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  byp_hit;
        logic [DATA_WIDTH-1:0] byp_data;

        assign ra = RADDR[i*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            byp_hit  = 1'b0;
            byp_data = '0;
            if (BYPASS) begin
                for (int unsigned j = 0; j < NUM_WR; j++) begin
                    if (win[j] && (waddr[j] == ra)) begin
                        byp_hit  = 1'b1;
                        byp_data = wdata[j];
                    end
                end
            end
        end

        // Gated by rst_n so a write presented during reset never leaks through.
        assign RDATA[i*DATA_WIDTH +: DATA_WIDTH] =
            (!rst_n || (ra == '0)) ? '0 : (byp_hit ? byp_data : mem[ra]);
        assign RBUSY[i] = rst_n && (ra != '0) && !byp_hit && pend[ra];
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: a bypassing and a non-bypassing
// instance share one stimulus and are compared against an array-based model.
module tb_regfile_mp_sb;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int NW = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NR*AW-1:0] raddr;
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;

    logic [NR*DW-1:0] rdata1, rdata0;
    logic [NR-1:0]    rbusy1, rbusy0;
    logic [NW-1:0]    wcoll1, wcoll0;

    regfile_mp_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst_n(rst_n), .RADDR(raddr), .RDATA(rdata1), .RBUSY(rbusy1),
        .WE(we), .WADDR(waddr), .WDATA(wdata), .RSV_EN(rsv_en), .RSV_ADDR(rsv_addr),
        .WCOLL(wcoll1));

    regfile_mp_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1'b0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .RADDR(raddr), .RDATA(rdata0), .RBUSY(rbusy0),
        .WE(we), .WADDR(waddr), .WDATA(wdata), .RSV_EN(rsv_en), .RSV_ADDR(rsv_addr),
        .WCOLL(wcoll0));

    int checks = 0;
    int errors = 0;

    // Stimulus in plain form
    int          ra [NR];
    bit          wen [NW];
    int          wa [NW];
    logic [31:0] wd [NW];
    bit          rsv_e;
    int          rsv_a;

    // Reference model state
    logic [31:0] m_reg [32];
    bit          m_pend [32];
    logic [NW-1:0] m_coll;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Lowest port writing nonzero address a this cycle, or -1.
    function automatic int winner(input int a);
        if (a == 0) return -1;
        for (int j = 0; j < NW; j++)
            if (wen[j] && wa[j] == a) return j;
        return -1;
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < NR; i++) ra[i] = 0;
        for (int j = 0; j < NW; j++) begin wen[j] = 1'b0; wa[j] = 0; wd[j] = '0; end
        rsv_e = 1'b0;
        rsv_a = 0;
    endtask

    // One cycle: apply inputs, check outputs, advance model over the edge.
    task automatic step();
        for (int i = 0; i < NR; i++) raddr[i*AW +: AW] = AW'(ra[i]);
        for (int j = 0; j < NW; j++) begin
            we[j]             = wen[j];
            waddr[j*AW +: AW] = AW'(wa[j]);
            wdata[j*DW +: DW] = wd[j];
        end
        rsv_en   = rsv_e;
        rsv_addr = AW'(rsv_a);
        #1;
        if (!rst_n) begin
            for (int a = 0; a < 32; a++) begin m_reg[a] = '0; m_pend[a] = 1'b0; end
            m_coll = '0;
        end
        for (int i = 0; i < NR; i++) begin
            int a = ra[i];
            int w = rst_n ? winner(a) : -1;
            logic [31:0] e1, e0;
            bit b1, b0;
            e0 = (!rst_n || a == 0) ? 32'h0 : m_reg[a];
            e1 = (w >= 0) ? wd[w] : e0;
            b0 = (!rst_n || a == 0) ? 1'b0 : m_pend[a];
            b1 = (w >= 0) ? 1'b0 : b0;
            check($sformatf("rdata_byp[%0d] x%0d", i, a), rdata1[i*DW +: DW], e1);
            check($sformatf("rdata_nobyp[%0d] x%0d", i, a), rdata0[i*DW +: DW], e0);
            check($sformatf("rbusy_byp[%0d] x%0d", i, a), 32'(rbusy1[i]), 32'(b1));
            check($sformatf("rbusy_nobyp[%0d] x%0d", i, a), 32'(rbusy0[i]), 32'(b0));
        end
        check("wcoll_byp", 32'(wcoll1), 32'(m_coll));
        check("wcoll_nobyp", 32'(wcoll0), 32'(m_coll));
        @(posedge clk);
        if (rst_n) begin
            for (int j = 0; j < NW; j++)
                m_coll[j] = wen[j] && wa[j] != 0 && winner(wa[j]) != j;
            for (int j = 0; j < NW; j++) begin
                if (wen[j] && wa[j] != 0) begin
                    if (winner(wa[j]) == j) m_reg[wa[j]] = wd[j];
                    m_pend[wa[j]] = 1'b0;
                end
            end
            if (rsv_e && rsv_a != 0) m_pend[rsv_a] = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        for (int a = 0; a < 32; a++) begin m_reg[a] = '0; m_pend[a] = 1'b0; end
        m_coll = '0;
        @(negedge clk);
        step();
        rst_n = 1'b1;

        // Reset contents on all addresses
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < NR; i++) ra[i] = b * NR + i;
            step();
        end

        // Two ports to distinct addresses
        clear_inputs();
        wen[0] = 1; wa[0] = 5; wd[0] = 32'hDEADBEEF;
        wen[1] = 1; wa[1] = 6; wd[1] = 32'h12345678;
        step();
        clear_inputs();
        ra[0] = 5; ra[1] = 6;
        step();
        check("x5_direct", rdata0[0 +: DW], 32'hDEADBEEF);
        check("x6_direct", rdata0[DW +: DW], 32'h12345678);

        // Collision on x7
        clear_inputs();
        wen[0] = 1; wa[0] = 7; wd[0] = 32'h1;
        wen[1] = 1; wa[1] = 7; wd[1] = 32'h2;
        step();
        check("wcoll_pulse", 32'(wcoll1), 32'h2);
        clear_inputs();
        ra[0] = 7;
        step();
        check("wcoll_clear", 32'(wcoll1), 32'h0);
        check("x7_direct", rdata1[0 +: DW], 32'h1);

        // Same-cycle bypass on x9
        clear_inputs();
        wen[0] = 1; wa[0] = 9; wd[0] = 32'hAA; ra[0] = 9;
        step();
        check("x9_stored", rdata0[0 +: DW], 32'hAA);

        // Scoreboard on x3
        clear_inputs();
        rsv_e = 1; rsv_a = 3; ra[0] = 3;
        step();
        clear_inputs();
        ra[0] = 3;
        step();
        check("x3_busy", 32'(rbusy0[0]), 32'h1);
        wen[1] = 1; wa[1] = 3; wd[1] = 32'h30;
        step();
        check("x3_released", 32'(rbusy0[0]), 32'h0);
        clear_inputs();
        rsv_e = 1; rsv_a = 3; wen[0] = 1; wa[0] = 3; wd[0] = 32'h33; ra[0] = 3;
        step();
        clear_inputs();
        ra[0] = 3;
        step();
        check("x3_rsv_wr_busy", 32'(rbusy1[0]), 32'h1);
        check("x3_rsv_wr_data", rdata1[0 +: DW], 32'h33);

        // x0 is immutable and never pending
        clear_inputs();
        wen[0] = 1; wa[0] = 0; wd[0] = 32'hFFFF; rsv_e = 1; rsv_a = 0;
        step();
        clear_inputs();
        step();
        check("x0_data", rdata1[0 +: DW], 32'h0);
        check("x0_busy", 32'(rbusy1[0]), 32'h0);

        // Reset mid-operation with pending bits and a write in flight
        clear_inputs();
        rsv_e = 1; rsv_a = 10; wen[0] = 1; wa[0] = 11; wd[0] = 32'h55;
        step();
        rst_n = 1'b0;
        ra[0] = 5; ra[1] = 10; ra[2] = 11; ra[3] = 3;
        wen[0] = 1; wa[0] = 5; wd[0] = 32'h77; rsv_e = 0;
        step();
        rst_n = 1'b1;
        clear_inputs();
        ra[0] = 5; ra[1] = 10; ra[2] = 11; ra[3] = 3;
        step();

        // Randomised traffic with small address range to force collisions
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            for (int i = 0; i < NR; i++)
                ra[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
            for (int j = 0; j < NW; j++) begin
                wen[j] = ($urandom_range(0, 2) != 0);
                wa[j]  = int'($urandom_range(0, 7));
                wd[j]  = $urandom;
            end
            rsv_e = ($urandom_range(0, 1) != 0);
            rsv_a = int'($urandom_range(0, 7));
            step();
        end
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file for the pipelined RISC-V core; successor of the fixed 4-read/2-write file.
- Generalised read/write port counts and width; x0 hardwired to zero; resettable storage.
- Adds deterministic write-port arbitration with collision reporting, optional same-cycle write-to-read bypass, and a per-register pending scoreboard for hazard detection.

Parameters:
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register width.
- NUM_RD, 4, number of read ports (>=1).
- NUM_WR, 2, number of write ports (>=1).
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- RADDR  in  NUM_RD*ADDR_WIDTH  read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- RDATA  out  NUM_RD*DATA_WIDTH  read data, combinational, same packing.
- RBUSY  out  NUM_RD  pending flag for each read address, combinational.
- WE  in  NUM_WR  write enables.
- WADDR  in  NUM_WR*ADDR_WIDTH  write addresses.
- WDATA  in  NUM_WR*DATA_WIDTH  write data.
- RSV_EN  in  1  reserve destination register (mark pending).
- RSV_ADDR  in  ADDR_WIDTH  register to reserve.
- WCOLL  out  NUM_WR  registered; bit j = 1 for one cycle after port j lost arbitration.

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, all pending bits = 0, WCOLL = 0. While in reset, RDATA = 0 and RBUSY = 0.
- Release is synchronous to the next rising edge; no writes are accepted in the cycle rst_n is low.
- Register 0: writes are ignored and never counted as a collision. Reserve of register 0 is ignored. Reads of register 0 return 0, and its RBUSY is always 0.
- Write arbitration:
  - Lowest-numbered port with WE=1 wins per address.
  - Other active ports targeting the same nonzero address are dropped; their WCOLL bit is set on the next edge for exactly one cycle.
  - Ports to distinct addresses all commit on the same edge.
  - Write latency: new value is stored at the rising edge.
- Read:
  - Combinational from storage.
  - With BYPASS=1: if the winning write port targets RADDR i (nonzero) in the current cycle, RDATA i = that port's WDATA.
  - With BYPASS=0: RDATA i shows the old value until after the edge.
- Scoreboard (one pending bit per register):
  - Set on the edge when RSV_EN=1.
  - Cleared on the edge when any WE targets that register.
  - Same register reserved and written in the same cycle: pending ends at 1 (new producer wins); the write data is still stored.
  - Re-reserving an already pending register keeps it at 1 (no count).
- RBUSY i = registered pending bit of RADDR i. With BYPASS=1, RBUSY i is forced to 0 when the current cycle has a winning write to RADDR i.
- Reset mid-operation discards in-flight writes and all pending bits.
- No X propagation: all outputs are defined for any address value.

Test Plan:
- Reset then read all 32 addresses -> RDATA = 0 and RBUSY = 0 on all ports; WCOLL = 0.
- Port 0 writes x5=0xDEADBEEF and port 1 writes x6=0x12345678 in the same cycle; next cycle read x5, x6 -> 0xDEADBEEF and 0x12345678; WCOLL = 00.
- Both ports write x7 (port 0 = 0x1, port 1 = 0x2) -> x7 = 0x1; WCOLL = 10 (bit 1 set) for exactly one cycle, then 00.
- BYPASS=1: write x9=0xAA while reading x9 in the same cycle -> RDATA = 0xAA combinationally. BYPASS=0 run: same cycle returns the old value 0, next cycle 0xAA.
- RSV_EN to x3 -> RBUSY for x3 = 1 from the next cycle. Write x3 -> RBUSY 0 after the edge (0 same cycle with BYPASS=1). Reserve and write x3 in the same cycle -> pending stays 1 and data is stored.
- Write x0=0xFFFF and reserve x0 -> reads 0 and RBUSY 0. Assert rst_n low mid-sequence with pending bits set -> all registers and pending bits are 0 immediately.
